// File: rtl/demux_lane_collector.sv
// demux_lane_collector
//
// Four-lane bit collector placed after a 1x4 demultiplexer. Each strobe takes
// in_y[in_sel] and shifts it into that lane's WIDTH-bit shift register. The
// first bit received ends up in the MSB. Completed words wait in a per-lane
// pending slot. They leave through one registered valid/ready port, and a
// round-robin arbiter picks which pending lane goes next. A strobe that arrives
// at a lane whose previous word is still pending is dropped, and it sets that
// lane's sticky overflow flag.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   strobe; in_sel/in_y sampled on this edge
//   in_sel     lane select; the bit taken is in_y[in_sel]
//   in_y       demux outputs (non-selected bits ignored)
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word while out_valid is high
//   out_data   assembled word, first-received bit in MSB
//   out_lane   lane the word came from
//   ovf        sticky per-lane overflow flags
//   clr_ovf    clears all ovf bits (a same-edge set wins)

module demux_lane_collector #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       in_sel,
  input  logic [3:0]       in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_lane,
  output logic [3:0]       ovf,
  input  logic             clr_ovf
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [3:0][WIDTH-1:0] sr_q, sr_d;
  logic [3:0][CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]            pend_q, pend_d;
  logic [1:0]            last_grant_q, last_grant_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic [1:0]            out_lane_q, out_lane_d;
  logic [3:0]            ovf_q, ovf_d;

  logic                  out_free;
  logic                  grant_valid;
  logic [1:0]            grant;
  logic [1:0]            cand;
  logic                  do_xfer;
  logic                  blocked;

  // Round-robin: scan starting at the lane after last_grant. last_grant itself
  // is checked last.
  always_comb begin
    grant_valid = 1'b0;
    grant       = last_grant_q;
    cand        = last_grant_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant_q + 2'(i);
      if (!grant_valid && pend_q[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
    end
  end

  assign out_free = !out_valid_q || out_ready;
  assign do_xfer  = out_free && grant_valid;
  // A lane being drained this edge is free to take the first bit of its next word.
  assign blocked  = pend_q[in_sel] && !(do_xfer && (grant == in_sel));

  always_comb begin
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_lane_d   = out_lane_q;
    ovf_d        = clr_ovf ? 4'b0000 : ovf_q;

    if (do_xfer) begin
      out_valid_d    = 1'b1;
      out_data_d     = sr_q[grant];
      out_lane_d     = grant;
      last_grant_d   = grant;
      pend_d[grant]  = 1'b0;
    end else if (out_free) begin
      out_valid_d = 1'b0;
    end

    if (in_valid) begin
      if (blocked) begin
        ovf_d[in_sel] = 1'b1;
      end else begin
        sr_d[in_sel] = {sr_q[in_sel][WIDTH-2:0], in_y[in_sel]};
        if (cnt_q[in_sel] == CntLast) begin
          cnt_d[in_sel]  = '0;
          pend_d[in_sel] = 1'b1;
        end else begin
          cnt_d[in_sel] = cnt_q[in_sel] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q         <= '0;
      cnt_q        <= '0;
      pend_q       <= '0;
      last_grant_q <= 2'd3;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_lane_q   <= '0;
      ovf_q        <= '0;
    end else begin
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_lane_q   <= out_lane_d;
      ovf_q        <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_demux_lane_collector.sv
module tb_demux_lane_collector;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [1:0]   in_sel = 2'd0;
  logic [3:0]   in_y = 4'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   out_lane;
  logic [3:0]   ovf;
  logic         clr_ovf = 1'b0;

  int checks = 0;
  int fails  = 0;

  demux_lane_collector #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One strobe on a lane; non-selected demux outputs carry random junk.
  task automatic strobe(input int lane, input logic b);
    logic [3:0] y;
    y        = 4'($urandom);
    y[lane]  = b;
    in_valid = 1'b1;
    in_sel   = 2'(lane);
    in_y     = y;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input int lane, input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) strobe(lane, w[i]);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [W-1:0] w;
    do_reset();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin fails++; $display("FAIL reset_data: got %0h expected 0", out_data); end
    checks++; if (out_lane !== 2'd0) begin fails++; $display("FAIL reset_lane: got %0d expected 0", out_lane); end
    checks++; if (ovf !== 4'd0) begin fails++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
    // Fill the output, a pending word and an overflow, then reset asynchronously.
    send_word(3, 8'hC3);
    send_word(3, 8'h3C);
    strobe(3, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_lane !== 2'd3 || ovf !== 4'b1000) begin
      fails++; $display("FAIL prereset_state: got v=%0b lane=%0d ovf=%0b expected v=1 lane=3 ovf=1000", out_valid, out_lane, ovf);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_lane !== 2'd0 || ovf !== 4'd0) begin
      fails++; $display("FAIL async_reset: got v=%0b d=%0h lane=%0d ovf=%0b expected all 0", out_valid, out_data, out_lane, ovf);
    end
    #1;
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    w = 8'($urandom);
    send_word(0, w);
    step();
    checks++; if (out_valid !== 1'b1 || out_lane !== 2'd0 || out_data !== w) begin
      fails++; $display("FAIL reset_first_lane0: got v=%0b lane=%0d d=%0h expected v=1 lane=0 d=%0h", out_valid, out_lane, out_data, w);
    end
    step();
  endtask

  task automatic test_single_word();
    do_reset();
    out_ready = 1'b1;
    send_word(0, 8'hB2);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_early: got %0b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hB2 || out_lane !== 2'd0) begin
      fails++; $display("FAIL single_word: got v=%0b d=%0h lane=%0d expected v=1 d=b2 lane=0", out_valid, out_data, out_lane);
    end
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_one_cycle: got %0b expected 0", out_valid); end
  endtask

  task automatic test_arbitration();
    logic [W-1:0] w0, w1, w2, w1b, w2b, w1c;
    do_reset();
    w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
    w1b = 8'($urandom); w2b = 8'($urandom); w1c = 8'($urandom);
    send_word(0, w0);
    step();
    send_word(1, w1);
    send_word(2, w2);
    checks++; if (out_valid !== 1'b1 || out_lane !== 2'd0 || out_data !== w0) begin
      fails++; $display("FAIL arb_busy: got v=%0b lane=%0d d=%0h expected v=1 lane=0 d=%0h", out_valid, out_lane, out_data, w0);
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_lane !== 2'd1 || out_data !== w1) begin
      fails++; $display("FAIL arb_first: got lane=%0d d=%0h expected lane=1 d=%0h", out_lane, out_data, w1);
    end
    step();
    checks++; if (out_valid !== 1'b1 || out_lane !== 2'd2 || out_data !== w2) begin
      fails++; $display("FAIL arb_second: got v=%0b lane=%0d d=%0h expected v=1 lane=2 d=%0h", out_valid, out_lane, out_data, w2);
    end
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arb_drain: got %0b expected 0", out_valid); end
    out_ready = 1'b0;
    send_word(1, w1b);
    step();
    send_word(2, w2b);
    send_word(1, w1c);
    out_ready = 1'b1;
    step();
    checks++; if (out_lane !== 2'd2 || out_data !== w2b) begin
      fails++; $display("FAIL arb_rotate_first: got lane=%0d d=%0h expected lane=2 d=%0h", out_lane, out_data, w2b);
    end
    step();
    checks++; if (out_lane !== 2'd1 || out_data !== w1c) begin
      fails++; $display("FAIL arb_rotate_second: got lane=%0d d=%0h expected lane=1 d=%0h", out_lane, out_data, w1c);
    end
    step();
  endtask

  task automatic test_overflow();
    logic [W-1:0] a, b;
    do_reset();
    a = 8'($urandom); b = 8'($urandom);
    send_word(3, a);
    send_word(3, b);
    checks++; if (ovf !== 4'd0) begin fails++; $display("FAIL ovf_none: got %0b expected 0", ovf); end
    strobe(3, 1'($urandom));
    checks++; if (ovf !== 4'b1000) begin fails++; $display("FAIL ovf_set: got %0b expected 1000", ovf); end
    checks++; if (out_valid !== 1'b1 || out_data !== a || out_lane !== 2'd3) begin
      fails++; $display("FAIL ovf_hold_a: got v=%0b d=%0h lane=%0d expected v=1 d=%0h lane=3", out_valid, out_data, out_lane, a);
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== b || out_lane !== 2'd3) begin
      fails++; $display("FAIL ovf_word_b: got v=%0b d=%0h lane=%0d expected v=1 d=%0h lane=3", out_valid, out_data, out_lane, b);
    end
    step();
    checks++; if (out_valid !== 1'b0 || ovf !== 4'b1000) begin
      fails++; $display("FAIL ovf_sticky: got v=%0b ovf=%0b expected v=0 ovf=1000", out_valid, ovf);
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    checks++; if (ovf !== 4'd0) begin fails++; $display("FAIL ovf_clear: got %0b expected 0", ovf); end
  endtask

  task automatic test_same_edge();
    logic [W-1:0] x, p, q;
    do_reset();
    x = 8'($urandom); p = 8'($urandom); q = 8'($urandom);
    send_word(0, x);
    step();
    send_word(2, p);
    out_ready = 1'b1;
    strobe(2, q[W-1]);
    checks++; if (out_valid !== 1'b1 || out_lane !== 2'd2 || out_data !== p || ovf !== 4'd0) begin
      fails++; $display("FAIL same_edge_xfer: got v=%0b lane=%0d d=%0h ovf=%0b expected v=1 lane=2 d=%0h ovf=0", out_valid, out_lane, out_data, ovf, p);
    end
    for (int i = W - 2; i >= 0; i--) strobe(2, q[i]);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL same_edge_gap: got %0b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_lane !== 2'd2 || out_data !== q || ovf !== 4'd0) begin
      fails++; $display("FAIL same_edge_next: got v=%0b lane=%0d d=%0h ovf=%0b expected v=1 lane=2 d=%0h ovf=0", out_valid, out_lane, out_data, ovf, q);
    end
    step();
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) strobe(1, 1'($urandom));
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    send_word(1, 8'h5A);
    step();
    checks++; if (out_valid !== 1'b1 || out_lane !== 2'd1 || out_data !== 8'h5A) begin
      fails++; $display("FAIL reset_mid_word: got v=%0b lane=%0d d=%0h expected v=1 lane=1 d=5a", out_valid, out_lane, out_data);
    end
    step();
  endtask

  // Random traffic against a word-level model: per-lane bit counts and values
  // built arithmetically, one pending slot per lane, one output slot.
  task automatic test_random();
    int unsigned mbits[4];
    int unsigned mword[4];
    int unsigned mpword[4];
    bit          mpend[4];
    bit          mov;
    int unsigned mdata, mlane, movf, mlast;
    int          g, lane, l;
    bit          iv, rdy, clr, free;
    logic [3:0]  y;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mbits[i] = 0; mword[i] = 0; mpword[i] = 0; mpend[i] = 0;
    end
    mov = 0; mdata = 0; mlane = 0; movf = 0; mlast = 3;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      iv   = ($urandom_range(0, 9) < 7);
      lane = int'($urandom_range(0, 3));
      y    = 4'($urandom);
      rdy  = (cyc % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 31) == 0);
      in_valid  = iv;
      in_sel    = 2'(lane);
      in_y      = y;
      out_ready = rdy;
      clr_ovf   = clr;

      free = !mov || rdy;
      g = -1;
      if (free) begin
        for (int k = 1; k <= 4; k++) begin
          l = int'((mlast + k) % 4);
          if (g < 0 && mpend[l]) g = l;
        end
      end
      if (g >= 0) begin
        mov = 1; mdata = mpword[g]; mlane = g; mlast = g; mpend[g] = 0;
      end else if (free) begin
        mov = 0;
      end
      if (clr) movf = 0;
      if (iv) begin
        if (mpend[lane]) begin
          movf = movf | (1 << lane);
        end else begin
          mword[lane] = (mword[lane] * 2 + (y[lane] ? 1 : 0)) % 256;
          mbits[lane]++;
          if (mbits[lane] == W) begin
            mpend[lane]  = 1;
            mpword[lane] = mword[lane];
            mword[lane]  = 0;
            mbits[lane]  = 0;
          end
        end
      end

      step();
      checks++; if (out_valid !== mov) begin fails++; $display("FAIL rnd_valid cyc %0d: got %0b expected %0b", cyc, out_valid, mov); end
      checks++; if (ovf !== 4'(movf)) begin fails++; $display("FAIL rnd_ovf cyc %0d: got %0b expected %0b", cyc, ovf, 4'(movf)); end
      if (mov) begin
        checks++; if (out_data !== 8'(mdata) || out_lane !== 2'(mlane)) begin
          fails++; $display("FAIL rnd_word cyc %0d: got d=%0h lane=%0d expected d=%0h lane=%0d", cyc, out_data, out_lane, 8'(mdata), mlane);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_arbitration();
    test_overflow();
    test_same_edge();
    test_reset_mid_word();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
